clahe_tile_lut_bank: RTL and testbench
======================================

// Module: clahe_tile_lut_bank
// PURPOSE
//  Parametrised ping-pong tile memory for CLAHE: two banks of TILES simple-dual-port RAMs (BINS x CNT_W).
//  Owns the ping-pong bank select, internal histogram increment (read-modify-write with bypass), bank clear
//  engine, CDF/LUT read-write port and a MAP_PORTS-wide parallel LUT read port for bilinear mapping.
//  Sits between clahe_hist_stat/clahe_cdf_calc (stats bank) and clahe_mapping (map bank).
// PARAMETERS
//  TILES      16   tiles per bank (2..64); TILE_W = $clog2(TILES)
//  BINS       256  grey-level bins, power of two; ADDR_W = $clog2(BINS)
//  CNT_W      16   histogram counter / RAM data width
//  LUT_W      8    CDF LUT width, stored in RAM bits [LUT_W-1:0], LUT_W <= CNT_W
//  MAP_PORTS  4    parallel mapping read ports (TL,TR,BL,BR order at 4)
// PORTS
//  pclk          in   1                    pixel clock, single clock domain
//  rst           in   1                    asynchronous, active-high reset
//  swap_req      in   1                    level; request bank swap at frame end
//  swap_ack      out  1                    1-cycle pulse: swap performed
//  clear_req     in   1                    pulse; clear current stats bank
//  clear_busy    out  1                    clear engine active
//  bank_sel      out  1                    0: stats=A map=B; 1: stats=B map=A
//  hist_valid    in   1                    pixel present
//  hist_tile     in   TILE_W               tile of pixel
//  hist_bin      in   ADDR_W               grey level of pixel
//  hist_drop     out  1                    1-cycle pulse: pixel discarded
//  cdf_tile      in   TILE_W               CDF port tile
//  cdf_addr      in   ADDR_W               CDF port bin
//  cdf_rd_en     in   1                    read stats bank
//  cdf_rd_data   out  CNT_W                read data, 1 cycle after cdf_rd_en
//  cdf_wr_en     in   1                    write LUT value into stats bank
//  cdf_wr_data   in   LUT_W                LUT value, zero-extended on write
//  map_tile      in   MAP_PORTS*TILE_W     packed tile index per port (port k at [k*TILE_W +: TILE_W])
//  map_addr      in   ADDR_W               common grey level for all map ports
//  map_data      out  MAP_PORTS*LUT_W      packed LUT results from map bank
// BEHAVIOUR
//  Reset: bank_sel=0, swap_ack=0, hist_drop=0, cdf_rd_data=0, map_data=0; FSM -> INIT_CLR, clear_busy=1.
//  FSM: INIT_CLR (clear both banks, BINS cycles, addr 0..BINS-1, all tiles in parallel) -> IDLE;
//   IDLE: swap_req & hist pipe empty -> toggle bank_sel, pulse swap_ack, go CLR (clear new stats bank);
//         clear_req -> CLR; swap_req has priority over simultaneous clear_req (clear_req then ignored).
//   CLR: BINS cycles on stats bank only -> IDLE; clear_busy=1 in INIT_CLR/CLR; clear_req ignored while busy.
//  Reset asserted mid-operation: immediate return to reset values, INIT_CLR restarts at address 0.
//  Histogram RMW: cycle 0 read stats[hist_tile][hist_bin]; cycle 1 write value+1, saturating at 2^CNT_W-1.
//   Bypass: if cycle-0 tile/bin equals the pixel being written in the same cycle, cycle-1 uses the
//   written value, not RAM dout; back-to-back identical pixels count exactly (N pixels -> +N).
//  hist_valid while clear_busy: pixel dropped, hist_drop pulses next cycle; no RAM write.
//  CDF port: cdf_wr_en over hist write on same tile (hist write dropped, hist_drop pulses); ignored while busy.
//   cdf_rd_en with cdf_wr_en same cycle/address: read returns old data (read-first).
//  Map port: reads map bank every cycle; latency 1; tile index and bank_sel registered alongside address
//   so the swap cycle stays coherent; multiple ports on same tile legal (shared RAM read, fan-out).
//  Map bank never written except by INIT_CLR/CLR of the opposite bank; map reads unaffected by stats clear.
// CONFIGURATION
//  CLAHE_MAP_OREG_EN defined: extra output register on map_data and cdf_rd_data, latency 2, reset 0.
//  Undefined: latency 1, outputs driven from RAM dout through the tile mux.
// STRUCTURE
//  Shared package clahe_pkg: TILE_W/ADDR_W derivation, FSM state encodings (INIT_CLR, IDLE, CLR), LUT_W.
//  Sub-module clahe_tile_ram: 1 write port, 1 sync read port, BINS x CNT_W, instanced 2*TILES times.
// TESTING
//  Reset release -> clear_busy high exactly 2*BINS cycles? No: INIT_CLR BINS cycles, all 2*TILES RAMs read 0.
//  5 consecutive hist_valid tile 3 bin 100 -> stats[3][100]==5 (bypass), neighbouring bins stay 0.
//  Preload bin to 2^CNT_W-2, 3 hits -> value saturates at 2^CNT_W-1, no wrap.
//  cdf_wr tile 7 addrs 0..255 data=addr, swap_req -> swap_ack 1 cycle, bank_sel=1, map_tile all 7,
//   map_addr 42 -> map_data all ports 42 after 1 cycle (2 with CLAHE_MAP_OREG_EN).
//  hist_valid during CLR -> hist_drop pulses, counts unchanged; clear_req+swap_req same cycle -> swap only.
//  Assert rst mid-CLR at addr 100 -> outputs reset, INIT_CLR restarts from 0, both banks zero after.

Source files
------------

// File: rtl/clahe_pkg.sv
// Shared CLAHE definitions: index-width derivation, clear-engine FSM states,
// default LUT width.
package clahe_pkg;

   localparam int DEF_LUT_W = 8;

   typedef enum logic [1:0] {
      ST_INIT_CLR = 2'd0,
      ST_IDLE     = 2'd1,
      ST_CLR      = 2'd2
   } clr_state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clahe_tile_ram.sv
// One tile histogram/LUT RAM: BINS x CNT_W, one write port, one registered
// read port (read-first). Ports: clk_i, rst_i (clears read register only),
// we_i/waddr_i/wdata_i write, raddr_i -> rdata_o one cycle later.
module clahe_tile_ram #(
   parameter int BINS   = 256,
   parameter int CNT_W  = 16,
   parameter int ADDR_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [CNT_W-1:0]  wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [CNT_W-1:0]  rdata_o
);

   logic [CNT_W-1:0] mem_q [BINS];
   logic [CNT_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) rdata_q <= '0;
      else       rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/clahe_tile_lut_bank.sv
// CLAHE ping-pong tile memory: two banks of TILES RAMs, histogram RMW with
// bypass, bank clear engine, CDF/LUT port and MAP_PORTS parallel map reads.
// Ports: pclk/rst; swap_req/swap_ack/bank_sel bank control; clear_req/
// clear_busy clear engine; hist_* pixel input and hist_drop; cdf_* stats
// bank access; map_tile/map_addr/map_data map bank reads.
// Option: CLAHE_MAP_OREG_EN adds an output register (latency 2).
module clahe_tile_lut_bank
   import clahe_pkg::*;
#(
   parameter int TILES     = 16,
   parameter int BINS      = 256,
   parameter int CNT_W     = 16,
   parameter int LUT_W     = DEF_LUT_W,
   parameter int MAP_PORTS = 4,
   parameter int TILE_W    = idx_w(TILES),
   parameter int ADDR_W    = idx_w(BINS)
) (
   input  logic                        pclk,
   input  logic                        rst,
   input  logic                        swap_req,
   output logic                        swap_ack,
   input  logic                        clear_req,
   output logic                        clear_busy,
   output logic                        bank_sel,
   input  logic                        hist_valid,
   input  logic [TILE_W-1:0]           hist_tile,
   input  logic [ADDR_W-1:0]           hist_bin,
   output logic                        hist_drop,
   input  logic [TILE_W-1:0]           cdf_tile,
   input  logic [ADDR_W-1:0]           cdf_addr,
   input  logic                        cdf_rd_en,
   output logic [CNT_W-1:0]            cdf_rd_data,
   input  logic                        cdf_wr_en,
   input  logic [LUT_W-1:0]            cdf_wr_data,
   input  logic [MAP_PORTS*TILE_W-1:0] map_tile,
   input  logic [ADDR_W-1:0]           map_addr,
   output logic [MAP_PORTS*LUT_W-1:0]  map_data
);

   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(BINS - 1);

   clr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
   logic              bank_sel_q, bank_sel_d;
   logic              swap_ack_q, hist_drop_q, hist_drop_d;
   logic              busy, clr_all, clr_stats, swap_go;

   logic              hist_acc, hist_empty;
   logic              v1_q;
   logic [TILE_W-1:0] tile1_q;
   logic [ADDR_W-1:0] bin1_q;
   logic              byp_q, byp_d;
   logic [CNT_W-1:0]  byp_val_q;
   logic              cdf_we, hist_cdf_hit, hist_we;
   logic [CNT_W-1:0]  hist_old, hist_new;

   logic [TILE_W-1:0] cdf_tile_q;
   logic              cdf_bank_q;
   logic [TILE_W-1:0] map_tile_q [MAP_PORTS];
   logic              map_bank_q;

   logic              ram_we    [2][TILES];
   logic [ADDR_W-1:0] ram_waddr [2][TILES];
   logic [ADDR_W-1:0] ram_raddr [2][TILES];
   logic [CNT_W-1:0]  ram_wdata [2][TILES];
   logic [CNT_W-1:0]  ram_rdata [2][TILES];
   logic              is_stats;

   logic [CNT_W-1:0]           cdf_c;
   logic [MAP_PORTS*LUT_W-1:0] map_c;

   // ---------------- clear / swap FSM ----------------
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) state_q <= ST_INIT_CLR;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_INIT_CLR,
         ST_CLR: begin
            if (clr_addr_q == ADDR_LAST) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            // a pending swap masks clear_req even while it waits for the pipe
            if (swap_req) begin
               if (hist_empty) state_d = ST_CLR;
            end else if (clear_req) begin
               state_d = ST_CLR;
            end
         end
         default: state_d = ST_INIT_CLR;
      endcase
   end

   always_comb begin
      busy      = 1'b1;
      clr_all   = 1'b0;
      clr_stats = 1'b0;
      swap_go   = 1'b0;
      unique case (state_q)
         ST_INIT_CLR: clr_all = 1'b1;
         ST_CLR:      clr_stats = 1'b1;
         ST_IDLE: begin
            busy    = 1'b0;
            swap_go = swap_req & hist_empty;
         end
         default: ;
      endcase
   end

   // BINS is a power of two, so the counter wraps back to 0 on the last bin
   assign clr_addr_d = busy ? clr_addr_q + 1'b1 : '0;
   assign bank_sel_d = bank_sel_q ^ swap_go;

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         clr_addr_q <= '0;
         bank_sel_q <= 1'b0;
         swap_ack_q <= 1'b0;
      end else begin
         clr_addr_q <= clr_addr_d;
         bank_sel_q <= bank_sel_d;
         swap_ack_q <= swap_go;
      end
   end

   // ---------------- histogram read-modify-write ----------------
   assign hist_acc     = hist_valid & ~busy;
   assign hist_empty   = ~hist_valid & ~v1_q;
   assign cdf_we       = cdf_wr_en & ~busy;
   assign hist_cdf_hit = cdf_we & (cdf_tile == tile1_q);
   assign hist_we      = v1_q & ~busy & ~hist_cdf_hit;

   // RAM read-first misses the write landing in the same cycle; reuse it
   assign hist_old = byp_q ? byp_val_q
                           : ram_rdata[bank_sel_q][tile1_q];
   assign hist_new = (hist_old == CNT_MAX) ? hist_old
                                           : hist_old + 1'b1;

   assign byp_d = hist_acc & hist_we
                & (hist_tile == tile1_q)
                & (hist_bin == bin1_q);

   assign hist_drop_d = (hist_valid & busy)
                      | (v1_q & (busy | hist_cdf_hit));

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         v1_q        <= 1'b0;
         tile1_q     <= '0;
         bin1_q      <= '0;
         byp_q       <= 1'b0;
         byp_val_q   <= '0;
         hist_drop_q <= 1'b0;
      end else begin
         v1_q        <= hist_acc;
         byp_q       <= byp_d;
         byp_val_q   <= hist_new;
         hist_drop_q <= hist_drop_d;
         if (hist_acc) begin
            tile1_q <= hist_tile;
            bin1_q  <= hist_bin;
         end
      end
   end

   // ---------------- RAM port steering ----------------
   // Stats read port: histogram lookup wins over the CDF read on its tile.
   always_comb begin
      is_stats = 1'b0;
      for (int b = 0; b < 2; b++) begin
         for (int t = 0; t < TILES; t++) begin
            is_stats        = (1'(b) == bank_sel_q);
            ram_we[b][t]    = 1'b0;
            ram_waddr[b][t] = clr_addr_q;
            ram_wdata[b][t] = '0;
            ram_raddr[b][t] = map_addr;
            if (is_stats) begin
               ram_raddr[b][t] =
                  (hist_acc && hist_tile == TILE_W'(t)) ? hist_bin
                                                        : cdf_addr;
            end
            if (clr_all) begin
               ram_we[b][t] = 1'b1;
            end else if (is_stats) begin
               if (clr_stats) begin
                  ram_we[b][t] = 1'b1;
               end else if (cdf_we && cdf_tile == TILE_W'(t)) begin
                  ram_we[b][t]    = 1'b1;
                  ram_waddr[b][t] = cdf_addr;
                  ram_wdata[b][t] = CNT_W'(cdf_wr_data);
               end else if (hist_we && tile1_q == TILE_W'(t)) begin
                  ram_we[b][t]    = 1'b1;
                  ram_waddr[b][t] = bin1_q;
                  ram_wdata[b][t] = hist_new;
               end
            end
         end
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_bank
      for (genvar t = 0; t < TILES; t++) begin : g_tile
         clahe_tile_ram #(
            .BINS   (BINS),
            .CNT_W  (CNT_W),
            .ADDR_W (ADDR_W)
         ) u_ram (
            .clk_i   (pclk),
            .rst_i   (rst),
            .we_i    (ram_we[b][t]),
            .waddr_i (ram_waddr[b][t]),
            .wdata_i (ram_wdata[b][t]),
            .raddr_i (ram_raddr[b][t]),
            .rdata_o (ram_rdata[b][t])
         );
      end
   end

   // ---------------- read-side select registers ----------------
   // Bank and tile are captured with the address so a swap edge cannot
   // mix old-bank data with new-bank selection.
   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         cdf_tile_q <= '0;
         cdf_bank_q <= 1'b0;
         map_bank_q <= 1'b0;
         for (int k = 0; k < MAP_PORTS; k++) map_tile_q[k] <= '0;
      end else begin
         if (cdf_rd_en) begin
            cdf_tile_q <= cdf_tile;
            cdf_bank_q <= bank_sel_q;
         end
         map_bank_q <= ~bank_sel_q;
         for (int k = 0; k < MAP_PORTS; k++) begin
            map_tile_q[k] <= map_tile[k*TILE_W +: TILE_W];
         end
      end
   end

   always_comb begin
      cdf_c = ram_rdata[cdf_bank_q][cdf_tile_q];
      map_c = '0;
      for (int k = 0; k < MAP_PORTS; k++) begin
         map_c[k*LUT_W +: LUT_W] =
            ram_rdata[map_bank_q][map_tile_q[k]][LUT_W-1:0];
      end
   end

`ifdef CLAHE_MAP_OREG_EN
   logic [CNT_W-1:0]           cdf_rd_q;
   logic [MAP_PORTS*LUT_W-1:0] map_data_q;

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         cdf_rd_q   <= '0;
         map_data_q <= '0;
      end else begin
         cdf_rd_q   <= cdf_c;
         map_data_q <= map_c;
      end
   end

   assign cdf_rd_data = cdf_rd_q;
   assign map_data    = map_data_q;
`else
   assign cdf_rd_data = cdf_c;
   assign map_data    = map_c;
`endif

   assign swap_ack   = swap_ack_q;
   assign clear_busy = busy;
   assign bank_sel   = bank_sel_q;
   assign hist_drop  = hist_drop_q;

endmodule

// File: tb/tb_clahe_tile_lut_bank.sv
// Directed bench for clahe_tile_lut_bank (default build and
// CLAHE_MAP_OREG_EN); a small CNT_W=4 instance covers saturation.
module tb_clahe_tile_lut_bank;

   localparam int BINS = 256;
`ifdef CLAHE_MAP_OREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        pclk = 1'b0;
   logic        rst  = 1'b1;
   logic        swap_req, swap_ack, clear_req, clear_busy, bank_sel;
   logic        hist_valid, hist_drop;
   logic [3:0]  hist_tile, cdf_tile;
   logic [7:0]  hist_bin, cdf_addr, cdf_wr_data, map_addr;
   logic        cdf_rd_en, cdf_wr_en;
   logic [15:0] cdf_rd_data;
   logic [15:0] map_tile;
   logic [31:0] map_data;

   logic       s_swap_ack, s_clear_busy, s_bank_sel, s_hist_drop;
   logic       s_hist_valid, s_hist_tile, s_cdf_tile, s_cdf_rd_en;
   logic [1:0] s_hist_bin, s_cdf_addr;
   logic [3:0] s_cdf_rd_data, s_map_data;

   int total = 0;
   int bad   = 0;

   always #5 pclk = ~pclk;

   clahe_tile_lut_bank dut (
      .pclk        (pclk),
      .rst         (rst),
      .swap_req    (swap_req),
      .swap_ack    (swap_ack),
      .clear_req   (clear_req),
      .clear_busy  (clear_busy),
      .bank_sel    (bank_sel),
      .hist_valid  (hist_valid),
      .hist_tile   (hist_tile),
      .hist_bin    (hist_bin),
      .hist_drop   (hist_drop),
      .cdf_tile    (cdf_tile),
      .cdf_addr    (cdf_addr),
      .cdf_rd_en   (cdf_rd_en),
      .cdf_rd_data (cdf_rd_data),
      .cdf_wr_en   (cdf_wr_en),
      .cdf_wr_data (cdf_wr_data),
      .map_tile    (map_tile),
      .map_addr    (map_addr),
      .map_data    (map_data)
   );

   clahe_tile_lut_bank #(
      .TILES(2), .BINS(4), .CNT_W(4), .LUT_W(4), .MAP_PORTS(1)
   ) dut_s (
      .pclk        (pclk),
      .rst         (rst),
      .swap_req    (1'b0),
      .swap_ack    (s_swap_ack),
      .clear_req   (1'b0),
      .clear_busy  (s_clear_busy),
      .bank_sel    (s_bank_sel),
      .hist_valid  (s_hist_valid),
      .hist_tile   (s_hist_tile),
      .hist_bin    (s_hist_bin),
      .hist_drop   (s_hist_drop),
      .cdf_tile    (s_cdf_tile),
      .cdf_addr    (s_cdf_addr),
      .cdf_rd_en   (s_cdf_rd_en),
      .cdf_rd_data (s_cdf_rd_data),
      .cdf_wr_en   (1'b0),
      .cdf_wr_data (4'd0),
      .map_tile    (1'b0),
      .map_addr    (2'd0),
      .map_data    (s_map_data)
   );

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic rd_stats(input int t, input int a,
                           output logic [15:0] v);
      cdf_tile  = 4'(t);
      cdf_addr  = 8'(a);
      cdf_rd_en = 1'b1;
      tick();
      cdf_rd_en = 1'b0;
      repeat (LAT - 1) tick();
      v = cdf_rd_data;
   endtask

   task automatic rd_map(input int t, input int a,
                         output logic [31:0] v);
      map_tile = {4{4'(t)}};
      map_addr = 8'(a);
      repeat (LAT) tick();
      v = map_data;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (clear_busy && n < 2000) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      logic [15:0] v;
      logic [31:0] m;
      int n;
      rst = 1'b1;
      repeat (3) tick();
      total++;
      if (bank_sel !== 1'b0) begin
         bad++; $display("FAIL rst_bank_sel: got %0h want 0", bank_sel);
      end
      total++;
      if (swap_ack !== 1'b0) begin
         bad++; $display("FAIL rst_swap_ack: got %0h want 0", swap_ack);
      end
      total++;
      if (hist_drop !== 1'b0) begin
         bad++; $display("FAIL rst_hist_drop: got %0h want 0", hist_drop);
      end
      total++;
      if (cdf_rd_data !== 16'h0) begin
         bad++; $display("FAIL rst_cdf_rd: got %0h want 0", cdf_rd_data);
      end
      total++;
      if (map_data !== 32'h0) begin
         bad++; $display("FAIL rst_map_data: got %0h want 0", map_data);
      end
      total++;
      if (clear_busy !== 1'b1) begin
         bad++; $display("FAIL rst_busy: got %0h want 1", clear_busy);
      end
      rst = 1'b0;
      wait_idle(n);
      total++;
      if (n != BINS) begin
         bad++; $display("FAIL init_clr_len: got %0d want %0d", n, BINS);
      end
      for (int t = 0; t < 16; t++) begin
         rd_stats(t, 0, v);
         total++;
         if (v !== 16'h0) begin
            bad++; $display("FAIL init_stats t%0d a0: got %0h want 0", t, v);
         end
         rd_stats(t, 255, v);
         total++;
         if (v !== 16'h0) begin
            bad++; $display("FAIL init_stats t%0d a255: got %0h want 0", t, v);
         end
         rd_map(t, 128, m);
         total++;
         if (m !== 32'h0) begin
            bad++; $display("FAIL init_map t%0d: got %0h want 0", t, m);
         end
      end
   endtask

   task automatic test_hist_bypass();
      logic [15:0] v;
      hist_tile  = 4'd3;
      hist_bin   = 8'd100;
      hist_valid = 1'b1;
      repeat (5) tick();
      hist_valid = 1'b0;
      repeat (2) tick();
      rd_stats(3, 100, v);
      total++;
      if (v !== 16'd5) begin
         bad++; $display("FAIL bypass_cnt: got %0d want 5", v);
      end
      rd_stats(3, 99, v);
      total++;
      if (v !== 16'd0) begin
         bad++; $display("FAIL bypass_bin99: got %0d want 0", v);
      end
      rd_stats(3, 101, v);
      total++;
      if (v !== 16'd0) begin
         bad++; $display("FAIL bypass_bin101: got %0d want 0", v);
      end
      rd_stats(2, 100, v);
      total++;
      if (v !== 16'd0) begin
         bad++; $display("FAIL bypass_tile2: got %0d want 0", v);
      end
   endtask

   task automatic test_saturate();
      s_hist_tile  = 1'b1;
      s_hist_bin   = 2'd2;
      s_hist_valid = 1'b1;
      repeat (14) tick();
      s_hist_valid = 1'b0;
      repeat (2) tick();
      s_cdf_tile  = 1'b1;
      s_cdf_addr  = 2'd2;
      s_cdf_rd_en = 1'b1;
      tick();
      s_cdf_rd_en = 1'b0;
      repeat (LAT - 1) tick();
      total++;
      if (s_cdf_rd_data !== 4'd14) begin
         bad++; $display("FAIL sat_pre: got %0d want 14", s_cdf_rd_data);
      end
      s_hist_valid = 1'b1;
      repeat (3) tick();
      s_hist_valid = 1'b0;
      repeat (2) tick();
      s_cdf_rd_en = 1'b1;
      tick();
      s_cdf_rd_en = 1'b0;
      repeat (LAT - 1) tick();
      total++;
      if (s_cdf_rd_data !== 4'd15) begin
         bad++; $display("FAIL sat_max: got %0d want 15", s_cdf_rd_data);
      end
      s_cdf_addr  = 2'd1;
      s_cdf_rd_en = 1'b1;
      tick();
      s_cdf_rd_en = 1'b0;
      repeat (LAT - 1) tick();
      total++;
      if (s_cdf_rd_data !== 4'd0) begin
         bad++; $display("FAIL sat_neigh: got %0d want 0", s_cdf_rd_data);
      end
   endtask

   task automatic test_cdf_swap();
      logic [15:0] v;
      logic [31:0] m;
      int n;
      for (int a = 0; a < BINS; a++) begin
         cdf_tile    = 4'd7;
         cdf_addr    = 8'(a);
         cdf_wr_data = 8'(a);
         cdf_wr_en   = 1'b1;
         tick();
      end
      cdf_addr    = 8'd43;
      cdf_wr_data = 8'h77;
      cdf_rd_en   = 1'b1;
      tick();
      cdf_wr_en = 1'b0;
      cdf_rd_en = 1'b0;
      repeat (LAT - 1) tick();
      total++;
      if (cdf_rd_data !== 16'd43) begin
         bad++; $display("FAIL read_first: got %0h want 2b", cdf_rd_data);
      end
      rd_stats(7, 43, v);
      total++;
      if (v !== 16'h77) begin
         bad++; $display("FAIL cdf_new: got %0h want 77", v);
      end
      rd_stats(7, 200, v);
      total++;
      if (v !== 16'd200) begin
         bad++; $display("FAIL cdf_200: got %0d want 200", v);
      end
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      total++;
      if (swap_ack !== 1'b1 || bank_sel !== 1'b1 || clear_busy !== 1'b1) begin
         bad++;
         $display("FAIL swap: got ack=%0h sel=%0h busy=%0h want 1 1 1",
                  swap_ack, bank_sel, clear_busy);
      end
      map_tile = {4{4'd7}};
      map_addr = 8'd42;
      tick();
      total++;
      if (swap_ack !== 1'b0) begin
         bad++; $display("FAIL swap_pulse: got %0h want 0", swap_ack);
      end
      repeat (LAT - 1) tick();
      total++;
      if (map_data !== {4{8'd42}}) begin
         bad++; $display("FAIL map_42: got %0h want 2a2a2a2a", map_data);
      end
      hist_tile  = 4'd3;
      hist_bin   = 8'd100;
      hist_valid = 1'b1;
      tick();
      hist_valid = 1'b0;
      total++;
      if (hist_drop !== 1'b1) begin
         bad++; $display("FAIL drop_pulse: got %0h want 1", hist_drop);
      end
      tick();
      total++;
      if (hist_drop !== 1'b0) begin
         bad++; $display("FAIL drop_end: got %0h want 0", hist_drop);
      end
      wait_idle(n);
      total++;
      if (clear_busy !== 1'b0) begin
         bad++; $display("FAIL clr_done: got busy %0h want 0", clear_busy);
      end
      rd_stats(3, 100, v);
      total++;
      if (v !== 16'd0) begin
         bad++; $display("FAIL drop_cnt: got %0d want 0", v);
      end
      rd_stats(7, 42, v);
      total++;
      if (v !== 16'd0) begin
         bad++; $display("FAIL newstats_clr: got %0d want 0", v);
      end
      rd_map(7, 43, m);
      total++;
      if (m !== {4{8'h77}}) begin
         bad++; $display("FAIL map_43: got %0h want 77777777", m);
      end
      map_tile = {4'd7, 4'd3, 4'd7, 4'd3};
      map_addr = 8'd100;
      repeat (LAT) tick();
      total++;
      if (map_data !== {8'd100, 8'd5, 8'd100, 8'd5}) begin
         bad++; $display("FAIL map_mixed: got %0h want 64056405", map_data);
      end
   endtask

   task automatic test_swap_priority();
      logic [15:0] v;
      logic [31:0] m;
      int n;
      swap_req  = 1'b1;
      clear_req = 1'b1;
      tick();
      swap_req  = 1'b0;
      clear_req = 1'b0;
      total++;
      if (swap_ack !== 1'b1 || bank_sel !== 1'b0) begin
         bad++;
         $display("FAIL prio_swap: got ack=%0h sel=%0h want 1 0",
                  swap_ack, bank_sel);
      end
      wait_idle(n);
      total++;
      if (n != BINS) begin
         bad++; $display("FAIL prio_clr_len: got %0d want %0d", n, BINS);
      end
      tick();
      total++;
      if (clear_busy !== 1'b0) begin
         bad++; $display("FAIL prio_no_clr: got busy %0h want 0", clear_busy);
      end
      rd_stats(7, 42, v);
      total++;
      if (v !== 16'd0) begin
         bad++; $display("FAIL prio_stats: got %0h want 0", v);
      end
      rd_map(7, 42, m);
      total++;
      if (m !== 32'h0) begin
         bad++; $display("FAIL prio_map: got %0h want 0", m);
      end
   endtask

   task automatic test_cdf_over_hist();
      logic [15:0] v;
      hist_tile  = 4'd2;
      hist_bin   = 8'd10;
      hist_valid = 1'b1;
      tick();
      hist_valid  = 1'b0;
      cdf_tile    = 4'd2;
      cdf_addr    = 8'd11;
      cdf_wr_data = 8'd9;
      cdf_wr_en   = 1'b1;
      tick();
      cdf_wr_en = 1'b0;
      total++;
      if (hist_drop !== 1'b1) begin
         bad++; $display("FAIL cdf_win_drop: got %0h want 1", hist_drop);
      end
      rd_stats(2, 10, v);
      total++;
      if (v !== 16'd0) begin
         bad++; $display("FAIL cdf_win_hist: got %0d want 0", v);
      end
      rd_stats(2, 11, v);
      total++;
      if (v !== 16'd9) begin
         bad++; $display("FAIL cdf_win_data: got %0d want 9", v);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] v;
      int n;
      hist_tile  = 4'd5;
      hist_bin   = 8'd200;
      hist_valid = 1'b1;
      tick();
      hist_valid = 1'b0;
      repeat (2) tick();
      rd_stats(5, 200, v);
      total++;
      if (v !== 16'd1) begin
         bad++; $display("FAIL mid_pre: got %0d want 1", v);
      end
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      wait_idle(n);
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      repeat (100) tick();
      rst = 1'b1;
      #1;
      total++;
      if (bank_sel !== 1'b0 || clear_busy !== 1'b1 || swap_ack !== 1'b0) begin
         bad++;
         $display("FAIL mid_rst_ctl: got sel=%0h busy=%0h ack=%0h want 0 1 0",
                  bank_sel, clear_busy, swap_ack);
      end
      total++;
      if (cdf_rd_data !== 16'h0 || map_data !== 32'h0 || hist_drop !== 1'b0) begin
         bad++;
         $display("FAIL mid_rst_out: got cdf=%0h map=%0h drop=%0h want 0 0 0",
                  cdf_rd_data, map_data, hist_drop);
      end
      tick();
      rst = 1'b0;
      wait_idle(n);
      total++;
      if (n != BINS) begin
         bad++; $display("FAIL mid_init_len: got %0d want %0d", n, BINS);
      end
      rd_stats(5, 200, v);
      total++;
      if (v !== 16'd0) begin
         bad++; $display("FAIL mid_stats: got %0d want 0", v);
      end
      rd_stats(7, 43, v);
      total++;
      if (v !== 16'd0) begin
         bad++; $display("FAIL mid_stats2: got %0d want 0", v);
      end
   endtask

   initial begin
      swap_req     = 1'b0;
      clear_req    = 1'b0;
      hist_valid   = 1'b0;
      hist_tile    = '0;
      hist_bin     = '0;
      cdf_tile     = '0;
      cdf_addr     = '0;
      cdf_rd_en    = 1'b0;
      cdf_wr_en    = 1'b0;
      cdf_wr_data  = '0;
      map_tile     = '0;
      map_addr     = '0;
      s_hist_valid = 1'b0;
      s_hist_tile  = 1'b0;
      s_hist_bin   = '0;
      s_cdf_tile   = 1'b0;
      s_cdf_addr   = '0;
      s_cdf_rd_en  = 1'b0;
      test_reset();
      test_hist_bypass();
      test_saturate();
      test_cdf_swap();
      test_swap_priority();
      test_cdf_over_hist();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
